// File: rtl/sys_pkg.sv
// Shared system types: ALU opcodes and the result-transmit FSM state encoding.
package sys_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    SEND_HI = 2'd2
  } tx_state_t;

endpackage

// File: rtl/result_fifo.sv
// Small circular result buffer with naturally wrapping pointers and a combinational head read.
module result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];

  // The caller only pushes when space exists or a pop frees a slot this cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is left out of reset; entries are only read once the count says they were written.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_result_tx.sv
// Buffers ALU results and serializes each as two DATA_WIDTH frames, low half first.
// Define ALU_TX_COMPACT_EN to send a single frame when the upper half of a result is zero.
module alu_result_tx
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  output logic                    BUSY,
  output logic                    DROP
);

  localparam int W = DATA_WIDTH;

  tx_state_t      state_q, state_d;
  logic [2*W-1:0] hold_q, hold_d;
  logic           drop_q, drop_d;
  logic           pop, push_ok;
  logic           fifo_full, fifo_empty;
  logic [2*W-1:0] fifo_head;

  result_fifo #(
    .WIDTH (2*W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (push_ok),
    .pop   (pop),
    .wdata (ALU_OUT),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full FIFO still accepts a result when the FSM frees a slot in the same cycle.
  assign push_ok = OUT_VALID && (!fifo_full || pop);
  assign drop_d  = OUT_VALID && !push_ok;

  // NOTE: every variable is given a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          hold_d  = fifo_head;
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        if (TX_READY) begin
          state_d = SEND_HI;
`ifdef ALU_TX_COMPACT_EN
          if (hold_q[2*W-1:W] == '0) begin
            if (!fifo_empty) begin
              pop     = 1'b1;
              hold_d  = fifo_head;
              state_d = SEND_LO;
            end else begin
              state_d = IDLE;
            end
          end
`endif
        end
      end
      SEND_HI: begin
        if (TX_READY) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            hold_d  = fifo_head;
            state_d = SEND_LO;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    TX_DATA = hold_q[W-1:0];
    if (state_q == SEND_HI) TX_DATA = hold_q[2*W-1:W];
  end

  assign TX_VALID = (state_q != IDLE);
  assign BUSY     = !fifo_empty || (state_q != IDLE);
  assign DROP     = drop_q;

endmodule

// File: tb/tb_alu_result_tx.sv
// Directed per-cycle vector bench for alu_result_tx (DATA_WIDTH=8, FIFO_DEPTH=2) plus a mid-frame reset sequence.
module tb_alu_result_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] ALU_OUT;
  logic        OUT_VALID;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;
  logic        BUSY;
  logic        DROP;

  int checks = 0;
  int errors = 0;

  alu_result_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ALU_OUT   (ALU_OUT),
    .OUT_VALID (OUT_VALID),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .BUSY      (BUSY),
    .DROP      (DROP)
  );

  always #5 CLK = ~CLK;

  // Inputs applied during a cycle and the outputs expected in that same cycle.
  typedef struct packed {
    logic        ov;
    logic [15:0] din;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        eb;
    logic        edrop;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ov, input logic [15:0] din, input logic rdy,
                     input logic ev, input logic [7:0] ed, input logic eb, input logic edrop);
    vec_t v;
    v.ov = ov; v.din = din; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.eb = eb; v.edrop = edrop;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [7:0] ed,
                               input logic eb, input logic edrop);
    check({tag, " tx_valid"}, 32'(TX_VALID), 32'(ev));
    if (ev) check({tag, " tx_data"}, 32'(TX_DATA), 32'(ed));
    check({tag, " busy"}, 32'(BUSY), 32'(eb));
    check({tag, " drop"}, 32'(DROP), 32'(edrop));
  endtask

  initial begin
    // 1: single result, ready high
    add(1, 16'h1234, 1, 0, 8'h00, 0, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h34, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h12, 1, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 0, 0);
    // 2: ready low for five cycles while the low frame is held
    add(1, 16'hABCD, 0, 0, 8'h00, 0, 0);
    add(0, 16'h0000, 0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 16'h0000, 0, 1, 8'hCD, 1, 0);
    add(0, 16'h0000, 1, 1, 8'hCD, 1, 0);
    add(0, 16'h0000, 1, 1, 8'hAB, 1, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 0, 0);
    // 3: overflow with ready low, 0x0404 dropped
    add(1, 16'h0101, 0, 0, 8'h00, 0, 0);
    add(1, 16'h0202, 0, 0, 8'h00, 1, 0);
    add(1, 16'h0303, 0, 1, 8'h01, 1, 0);
    add(1, 16'h0404, 0, 1, 8'h01, 1, 0);
    add(0, 16'h0000, 0, 1, 8'h01, 1, 1);
    add(0, 16'h0000, 1, 1, 8'h01, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h01, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h02, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h02, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h03, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h03, 1, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 0, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 0, 0);
    // 4: back-to-back results, no valid gap
    add(1, 16'h1111, 1, 0, 8'h00, 0, 0);
    add(1, 16'h2222, 1, 0, 8'h00, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h11, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h11, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h22, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h22, 1, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 0, 0);
    // 5: zero upper half
    add(1, 16'h0042, 1, 0, 8'h00, 0, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h42, 1, 0);
`ifndef ALU_TX_COMPACT_EN
    add(0, 16'h0000, 1, 1, 8'h00, 1, 0);
`endif
    add(0, 16'h0000, 1, 0, 8'h00, 0, 0);
    // 7: full FIFO with push and pop in the same cycle, no drop
    add(1, 16'hA1A0, 0, 0, 8'h00, 0, 0);
    add(1, 16'hB1B0, 0, 0, 8'h00, 1, 0);
    add(1, 16'hC1C0, 0, 1, 8'hA0, 1, 0);
    add(0, 16'h0000, 1, 1, 8'hA0, 1, 0);
    add(1, 16'hD1D0, 1, 1, 8'hA1, 1, 0);
    add(0, 16'h0000, 1, 1, 8'hB0, 1, 0);
    add(0, 16'h0000, 1, 1, 8'hB1, 1, 0);
    add(0, 16'h0000, 1, 1, 8'hC0, 1, 0);
    add(0, 16'h0000, 1, 1, 8'hC1, 1, 0);
    add(0, 16'h0000, 1, 1, 8'hD0, 1, 0);
    add(0, 16'h0000, 1, 1, 8'hD1, 1, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 0, 0);
    // 8: two consecutive drops give two consecutive DROP cycles
    add(1, 16'h1E10, 0, 0, 8'h00, 0, 0);
    add(1, 16'h2E20, 0, 0, 8'h00, 1, 0);
    add(1, 16'h3E30, 0, 1, 8'h10, 1, 0);
    add(1, 16'h4E40, 0, 1, 8'h10, 1, 0);
    add(1, 16'h5E50, 0, 1, 8'h10, 1, 1);
    add(0, 16'h0000, 0, 1, 8'h10, 1, 1);
    add(0, 16'h0000, 1, 1, 8'h10, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h1E, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h20, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h2E, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h30, 1, 0);
    add(0, 16'h0000, 1, 1, 8'h3E, 1, 0);
    add(0, 16'h0000, 1, 0, 8'h00, 0, 0);

    RST = 1'b1; ALU_OUT = '0; OUT_VALID = 1'b0; TX_READY = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("reset tx_valid", 32'(TX_VALID), 32'h0);
    check("reset tx_data",  32'(TX_DATA),  32'h0);
    check("reset busy",     32'(BUSY),     32'h0);
    check("reset drop",     32'(DROP),     32'h0);
    RST = 1'b0;

    foreach (vecs[i]) begin
      check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].eb, vecs[i].edrop);
      OUT_VALID = vecs[i].ov;
      ALU_OUT   = vecs[i].din;
      TX_READY  = vecs[i].rdy;
      @(negedge CLK);
    end

    // 6: reset while in SEND_HI with one result still buffered
    OUT_VALID = 1'b1; ALU_OUT = 16'h5566; TX_READY = 1'b1;
    @(negedge CLK);
    ALU_OUT = 16'h7788;
    @(negedge CLK);
    OUT_VALID = 1'b0;
    check_outputs("rst_mid lo", 1'b1, 8'h66, 1'b1, 1'b0);
    @(negedge CLK);
    check_outputs("rst_mid hi", 1'b1, 8'h55, 1'b1, 1'b0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_outputs("rst_mid after", 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst_mid tx_data", 32'(TX_DATA), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      check_outputs($sformatf("rst_mid quiet%0d", i), 1'b0, 8'h00, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
